// File: rtl/cq_viola_pio_pkg.sv
// cq_viola_pio_pkg: register map, edge-type codes and edge selection shared by the button PIO
package cq_viola_pio_pkg;
    typedef logic [31:0] word_t;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic word_t edge_sel(word_t rise, word_t fall, int edge_type);
        return edge_type == EDGE_RISE ? rise : edge_type == EDGE_FALL ? fall : rise | fall;
    endfunction
endpackage

// File: rtl/cq_viola_debounce.sv
// cq_viola_debounce: 2-flop synchroniser plus hold-time debouncer for one input bit
module cq_viola_debounce #(
    parameter int DEBOUNCE = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic stable_q, stable_d, mismatch, done;

    always_comb begin
        sync_d = {sync_q[0], in_raw};
        mismatch = sync_q[1] ^ stable_q;
        done = mismatch && cnt_q == LAST;
        stable_d = done ? sync_q[1] : stable_q;
        cnt_d = (mismatch && !done) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
endmodule

// File: rtl/cq_viola_button.sv
// cq_viola_button: Avalon-MM input PIO with debounced inputs, sticky edge capture and level IRQ
module cq_viola_button
    import cq_viola_pio_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEBOUNCE  = 50000,
    parameter int EDGE_TYPE = EDGE_ANY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] level, prev_q, prev_d, cap_q, cap_d, mask_q, mask_d, hit, clr;
    logic irq_q, irq_d, wr, rd, unused_wd;
    logic [31:0] rdata_q, rdata_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cq_viola_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk(clk),
            .reset(reset),
            .in_raw(in_port[i]),
            .stable(level[i])
        );
    end

    always_comb begin
        wr = chipselect & ~write_n;
        rd = chipselect & write_n;
        prev_d = level;
        hit = WIDTH'(edge_sel(32'(level & ~prev_q), 32'(~level & prev_q), EDGE_TYPE));
        clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        // OR-ing the new edges after the clear keeps an event that lands on a W1C write
        cap_d = (cap_q & ~clr) | hit;
        mask_d = (wr && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : mask_q;
        irq_d = |(cap_q & mask_q);
        rdata_d = !rd ? rdata_q :
                  address == ADDR_DATA    ? 32'(level)  :
                  address == ADDR_IRQMASK ? 32'(mask_q) :
                  address == ADDR_EDGECAP ? 32'(cap_q)  : '0;
    end

    assign unused_wd = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            cap_q <= '0;
            mask_q <= '0;
            irq_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            prev_q <= prev_d;
            cap_q <= cap_d;
            mask_q <= mask_d;
            irq_q <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq = irq_q;
endmodule

// File: tb/tb_cq_viola_button.sv
// tb_cq_viola_button: drives three button PIOs (rise/fall/any edge) against a behavioural model
module tb_cq_viola_button;
    localparam int W = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] address = '0;
    logic chipselect = 1'b0;
    logic write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0] rdata [3];
    logic irq_o [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        cq_viola_button #(.WIDTH(W), .DEBOUNCE(DB), .EDGE_TYPE(k)) u_dut (
            .clk(clk),
            .reset(reset),
            .address(address),
            .chipselect(chipselect),
            .write_n(write_n),
            .writedata(writedata),
            .readdata(rdata[k]),
            .in_port(in_port),
            .irq(irq_o[k])
        );
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a level is accepted once the synchronised input has
    // disagreed with it for DB consecutive cycles.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_prev = '0, m_mask = '0;
    int m_run [W];
    logic [W-1:0] m_cap [3];
    logic m_irq [3];
    logic [31:0] m_rd [3];

    initial begin
        for (int i = 0; i < W; i++) m_run[i] = 0;
        for (int k = 0; k < 3; k++) begin
            m_cap[k] = '0;
            m_irq[k] = 1'b0;
            m_rd[k] = '0;
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0; m_mask = '0;
                for (int i = 0; i < W; i++) m_run[i] = 0;
                for (int k = 0; k < 3; k++) begin
                    m_cap[k] = '0;
                    m_irq[k] = 1'b0;
                    m_rd[k] = '0;
                end
            end else begin
                logic wr, rd;
                logic [W-1:0] rise, fall, clr, ev;
                wr = chipselect && !write_n;
                rd = chipselect && write_n;
                rise = m_lvl & ~m_prev;
                fall = ~m_lvl & m_prev;
                clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
                for (int k = 0; k < 3; k++) begin
                    if (rd)
                        m_rd[k] = address == 2'd0 ? {28'd0, m_lvl} :
                                  address == 2'd2 ? {28'd0, m_mask} :
                                  address == 2'd3 ? {28'd0, m_cap[k]} : 32'd0;
                    m_irq[k] = |(m_cap[k] & m_mask);
                    ev = k == 0 ? rise : k == 1 ? fall : (rise | fall);
                    m_cap[k] = (m_cap[k] & ~clr) | ev;
                end
                if (wr && address == 2'd2) m_mask = writedata[W-1:0];
                m_prev = m_lvl;
                for (int i = 0; i < W; i++) begin
                    if (m_s2[i] != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_lvl[i] = m_s2[i];
                            m_run[i] = 0;
                        end
                    end else m_run[i] = 0;
                end
                m_s2 = m_s1;
                m_s1 = in_port;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_readdata[%0d]", k), rdata[k], m_rd[k]);
            chk($sformatf("model_irq[%0d]", k), {31'd0, irq_o[k]}, {31'd0, m_irq[k]});
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        tick;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        int hold;
        int op;
        repeat (3) tick;
        reset = 1'b0;
        rd(2'd0); chk("reset_data", rdata[0], 32'h0);
        rd(2'd2); chk("reset_mask", rdata[0], 32'h0);
        rd(2'd3); chk("reset_cap", rdata[0], 32'h0);

        in_port = 4'b0001;
        repeat (14) tick;
        rd(2'd0); chk("data_bit0", rdata[0], 32'h1);
        rd(2'd3);
        chk("cap_rise", rdata[0], 32'h1);
        chk("cap_fall_none", rdata[1], 32'h0);
        chk("cap_any", rdata[2], 32'h1);
        chk("irq_masked", {31'd0, irq_o[0]}, 32'h0);

        in_port = 4'b0011;
        repeat (5) tick;
        in_port = 4'b0001;
        repeat (15) tick;
        rd(2'd0); chk("glitch_data", rdata[0], 32'h1);
        rd(2'd3); chk("glitch_cap", rdata[0], 32'h1);

        in_port = 4'b0011;
        repeat (12) tick;
        in_port = 4'b0001;
        repeat (15) tick;
        rd(2'd3);
        chk("pulse_cap_rise", rdata[0], 32'h3);
        chk("pulse_cap_fall", rdata[1], 32'h2);
        chk("pulse_cap_any", rdata[2], 32'h3);
        rd(2'd0); chk("pulse_data", rdata[0], 32'h1);

        wr(2'd2, 32'h1);
        chk("irq_before", {31'd0, irq_o[0]}, 32'h0);
        tick;
        chk("irq_after_mask", {31'd0, irq_o[0]}, 32'h1);
        chk("irq_fall_inst", {31'd0, irq_o[1]}, 32'h0);
        wr(2'd3, 32'h1);
        chk("irq_still", {31'd0, irq_o[0]}, 32'h1);
        tick;
        chk("irq_cleared", {31'd0, irq_o[0]}, 32'h0);
        rd(2'd3); chk("cap_after_w1c", rdata[0], 32'h2);

        in_port = 4'b0000;
        repeat (15) tick;
        wr(2'd3, 32'hF);
        tick;
        in_port = 4'b0001;
        repeat (10) tick;
        wr(2'd3, 32'h1);
        rd(2'd3);
        chk("set_beats_clear", rdata[0], 32'h1);
        chk("set_beats_clear_any", rdata[2], 32'h1);
        chk("set_beats_clear_fall", rdata[1], 32'h0);
        chk("irq_reraised", {31'd0, irq_o[0]}, 32'h1);

        in_port = 4'b0101;
        repeat (4) tick;
        reset = 1'b1;
        #1;
        chk("async_rst_data", rdata[0], 32'h0);
        chk("async_rst_irq", {31'd0, irq_o[0]}, 32'h0);
        repeat (2) tick;
        reset = 1'b0;
        repeat (20) tick;
        rd(2'd0); chk("post_rst_data", rdata[0], 32'h5);
        rd(2'd3);
        chk("post_rst_cap_rise", rdata[0], 32'h5);
        chk("post_rst_cap_fall", rdata[1], 32'h0);
        chk("post_rst_cap_any", rdata[2], 32'h5);
        rd(2'd2); chk("post_rst_mask", rdata[0], 32'h0);

        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold = $urandom_range(1, 20);
            end
            hold--;
            op = $urandom_range(0, 3);
            address = 2'($urandom);
            writedata = $urandom;
            chipselect = op < 2;
            write_n = op != 1;
            tick;
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
